// File: rtl/sorting_pkg.sv
// Shared definitions for the packet-granular sorting-engine arbiter:
// FSM state encoding, default parameter values and the width helper
// for the optional packet-length counter.
package sorting_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } arb_state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_DATA_W      = 64;
  localparam int DEF_MAX_PKT_LEN = 256;

  // Counter must be able to hold MAX_PKT_LEN itself.
  function automatic int len_cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sorting_rr_pick.sv
// Combinational round-robin picker. Searches the request vector starting
// one position above last_grant, wrapping modulo N_REQ, and returns the
// first requester found together with a found flag.
module sorting_rr_pick
  import sorting_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int CH_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [CH_W-1:0]  last_grant,
  output logic [CH_W-1:0]  winner,
  output logic             found
);

  logic [CH_W-1:0]  cand [N_REQ];
  logic [N_REQ-1:0] hit;

  // cand[gi] is the requester at search distance gi+1 from last_grant.
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [CH_W:0] sum;
    assign sum      = {1'b0, last_grant} + (CH_W+1)'(gi + 1);
    assign cand[gi] = (sum >= (CH_W+1)'(N_REQ)) ? CH_W'(sum - (CH_W+1)'(N_REQ))
                                                : sum[CH_W-1:0];
    assign hit[gi]  = req[cand[gi]];
  end

  // Priority encode on search distance: the nearest hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        winner = cand[k];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sorting_pkt_arbiter.sv
// Packet-granular round-robin arbiter in front of a shared sorting engine.
// A requester presenting SOP is granted after one bubble cycle and then
// owns the engine until its EOP transfers; data passes through with zero
// latency and the granted channel is reported on src_channel_o.
// Optional feature: define SORTING_ARB_LEN_CHECK_EN to enable the
// MAX_PKT_LEN overflow check (forced EOP, sticky err_o, DROP state).
module sorting_pkt_arbiter
  import sorting_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
  localparam int CH_W       = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic [N_REQ*DATA_W-1:0] snk_data_i,
  input  logic [N_REQ-1:0]        snk_startofpacket_i,
  input  logic [N_REQ-1:0]        snk_endofpacket_i,
  input  logic [N_REQ-1:0]        snk_valid_i,
  output logic [N_REQ-1:0]        snk_ready_o,
  output logic [DATA_W-1:0]       src_data_o,
  output logic                    src_startofpacket_o,
  output logic                    src_endofpacket_o,
  output logic                    src_valid_o,
  input  logic                    src_ready_i,
  output logic [CH_W-1:0]         src_channel_o,
  output logic                    err_o
);

  localparam int CNT_W = len_cnt_width(MAX_PKT_LEN);

  arb_state_t       state_reg;
  arb_state_t       state_next;
  logic [CH_W-1:0]  grant_reg;
  logic [CH_W-1:0]  last_grant_reg;

  logic [N_REQ-1:0] sop_req;
  logic [CH_W-1:0]  pick_idx;
  logic             pick_found;

  logic [DATA_W-1:0] snk_data_arr [N_REQ];
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_sop;
  logic              sel_eop;
  logic              xfer;

  // Unpack the flat sink bus into one word per requester.
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_split
    assign snk_data_arr[gi] = snk_data_i[gi*DATA_W +: DATA_W];
  end

  // Only a valid SOP can open a packet.
  assign sop_req = snk_valid_i & snk_startofpacket_i;

  sorting_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req        (sop_req),
    .last_grant (last_grant_reg),
    .winner     (pick_idx),
    .found      (pick_found)
  );

  assign sel_data  = snk_data_arr[grant_reg];
  assign sel_valid = snk_valid_i[grant_reg];
  assign sel_sop   = snk_startofpacket_i[grant_reg];
  assign sel_eop   = snk_endofpacket_i[grant_reg];
  assign xfer      = (state_reg == BUSY) && sel_valid && src_ready_i;

  assign src_channel_o = grant_reg;

`ifdef SORTING_ARB_LEN_CHECK_EN
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;
  logic             len_last;

  // High while the word in flight would be the MAX_PKT_LEN-th of the packet.
  assign len_last = (cnt_reg == CNT_W'(MAX_PKT_LEN - 1));
  assign err_o    = err_reg;

  // Count words of the current packet and latch any overflow.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE) begin
        cnt_reg <= '0;
      end else if (xfer) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (xfer && len_last && !sel_eop) begin
        err_reg <= 1'b1;
      end
    end
  end
`else
  // Keeps the length parameter referenced when the check is compiled out.
  logic [CNT_W-1:0] len_unused;
  assign len_unused = '0;
  assign err_o      = 1'b0;
`endif

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= CH_W'(N_REQ - 1);
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && pick_found) begin
        grant_reg      <= pick_idx;
        last_grant_reg <= pick_idx;
      end
    end
  end

  // Next-state logic: grant on SOP, release on EOP transfer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (sel_eop) begin
            state_next = IDLE;
          end
`ifdef SORTING_ARB_LEN_CHECK_EN
          else if (len_last) begin
            state_next = DROP;
          end
`endif
        end
      end
`ifdef SORTING_ARB_LEN_CHECK_EN
      DROP: begin
        if (sel_valid && sel_eop) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Output logic: pass-through from the granted sink while BUSY.
  always_comb begin
    snk_ready_o         = '0;
    src_valid_o         = 1'b0;
    src_data_o          = sel_data;
    src_startofpacket_o = sel_sop;
    src_endofpacket_o   = sel_eop;
    case (state_reg)
      BUSY: begin
        src_valid_o            = sel_valid;
        snk_ready_o[grant_reg] = src_ready_i;
`ifdef SORTING_ARB_LEN_CHECK_EN
        if (len_last) begin
          src_endofpacket_o = 1'b1;
        end
`endif
      end
`ifdef SORTING_ARB_LEN_CHECK_EN
      DROP: begin
        snk_ready_o[grant_reg] = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/sorting_pkt_arbiter.md
# sorting_pkt_arbiter

Packet-granular round-robin arbiter that shares one sorting engine between N_REQ upstream Avalon-ST packet sources. It sits directly in front of the sorter's sink port. Once a requester wins, it is locked to the engine from start-of-packet to end-of-packet, so packets are never interleaved. It reports the winning channel alongside the data, so downstream logic can route the sorted result back to the right requester.

## Interface
- N_REQ, 4: number of requesters; must be ≥2.
- DATA_W, 64: data word width, equal to the sorter's bus width.
- MAX_PKT_LEN, 256: maximum words per packet; used only when the length check is compiled in.
- CH_W, $clog2(N_REQ): channel index width (localparam).

Ports:
- clk_i  in  1  the single clock.
- srst_i  in  1  reset; asynchronous, active-high.
- snk_data_i  in  N_REQ*DATA_W  requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- snk_startofpacket_i  in  N_REQ  per-requester SOP.
- snk_endofpacket_i  in  N_REQ  per-requester EOP.
- snk_valid_i  in  N_REQ  per-requester valid.
- snk_ready_o  out  N_REQ  per-requester ready.
- src_data_o  out  DATA_W  data to the sorter.
- src_startofpacket_o  out  1  SOP to the sorter.
- src_endofpacket_o  out  1  EOP to the sorter.
- src_valid_o  out  1  valid to the sorter.
- src_ready_i  in  1  sorter ready.
- src_channel_o  out  CH_W  index of the granted requester; stable for the whole packet.
- err_o  out  1  sticky length-overflow flag.

## Operation
- States are IDLE, BUSY and DROP. DROP exists only when the length check is compiled in.
- **IDLE**
  - Candidates are requesters i with snk_valid_i[i] & snk_startofpacket_i[i].
  - The winner is the first candidate found searching from last_grant+1 upward, wrapping modulo N_REQ.
  - On any candidate: register grant := winner, set last_grant := winner, go to BUSY.
  - All snk_ready_o are 0 and src_valid_o is 0.
- **BUSY (grant g)**, a combinational pass-through:
  - src_data_o, src_startofpacket_o, src_endofpacket_o and src_valid_o come from requester g.
  - snk_ready_o[g] = src_ready_i; every other snk_ready_o bit is 0.
  - A transfer is src_valid_o & src_ready_i.
  - A transfer with EOP returns the FSM to IDLE.
- A valid word from a non-granted requester, or a non-SOP valid word in IDLE, is never accepted. Its ready stays 0; this is an upstream protocol violation, and the block does not discard the word.
- A single-word packet (SOP and EOP together) is legal: IDLE → BUSY → IDLE.
- A SOP seen mid-packet from the granted requester is forwarded unchanged; the arbiter does not police it.
- src_channel_o = grant, held from the IDLE→BUSY transition until the next grant.

## Timing
- Reset values:
  - FSM state = IDLE.
  - grant = 0 and src_channel_o = 0.
  - last_grant = N_REQ-1, so requester 0 wins first.
  - word count = 0 and err_o = 0.
  - src_valid_o = 0 and snk_ready_o = 0. Data and SOP/EOP outputs are don't-care while valid is 0.
- Arbitration costs exactly 1 bubble cycle per packet:
  - A request seen in cycle t is granted at edge t+1.
  - The first word can transfer in cycle t+1.
- Data latency is 0 cycles: BUSY is combinational from the granted sink to the source.
- After an EOP transfer in cycle t, the FSM is in IDLE in cycle t+1. The next packet's first word transfers no earlier than cycle t+2.
- Reset asserted mid-packet forces IDLE immediately. The sorter sees a truncated packet; recovering from that is the sorter's responsibility.

## Configuration
- SORTING_ARB_LEN_CHECK_EN defined:
  - A word counter, $clog2(MAX_PKT_LEN+1) bits wide, counts transfers in BUSY.
  - If the MAX_PKT_LEN-th transfer lacks EOP, src_endofpacket_o is forced to 1 on that word and err_o is set (sticky until reset).
  - The FSM then goes to DROP. In DROP, snk_ready_o[g] = 1, src_valid_o = 0, and words are discarded until requester g's EOP is accepted; then the FSM returns to IDLE.
- Macro undefined: no counter, no DROP state, err_o tied to 0.

## Structure
- Package sorting_pkg holds:
  - the state enum typedef (IDLE/BUSY/DROP);
  - the default parameter constants;
  - a function computing the counter width.
- Sub-module sorting_rr_pick: combinational round-robin picker. Inputs are the request vector and last_grant. Outputs are the winner index and a found flag.

## Test plan
- Single requester: requester 1 sends a 4-word packet with src_ready_i=1. Expect a grant after 1 bubble, src_channel_o=1, 4 transfers with SOP on word 1 and EOP on word 4, and ready to requesters 0, 2 and 3 held at 0.
- All four requesters present SOP at once, right after reset. Expect the grant order 0,1,2,3,0. Packets must not interleave, and there must be exactly 1 idle cycle between packets.
- Backpressure: src_ready_i toggles every cycle during a 5-word packet. Expect exactly 5 transfers, unchanged data, and snk_ready_o[g] mirroring src_ready_i.
- srst_i asserted asynchronously during word 3 of a packet. Expect src_valid_o=0 and snk_ready_o=0 immediately. After release, expect requester 0 to be granted first.
- With SORTING_ARB_LEN_CHECK_EN and MAX_PKT_LEN=8, send a 10-word packet. Expect word 8 forwarded with forced EOP, err_o=1, and words 9–10 accepted but not forwarded. The next packet must then arbitrate normally.
- Single-word packets (SOP and EOP together) from requesters 2 and 3 arriving simultaneously. Expect two single-word transfers in order 2 then 3, each followed by IDLE.
